// File: rtl/mips_core.sv
// mips_core -- single-cycle MIPS subset core (lw, sw, beq, j, add/sub/and/or/slt).
// Instruction and data memories live outside the core and are read combinationally.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   pcout / inst      fetch address and fetched instruction
//   dmemout           data memory read data at aluout
//   aluout / rd2      data memory address / write data
//   waddrout, wdout, rd1, aluop2out, ALUCtr  datapath debug taps
//   RegDst..RegWrite, ALUOp                  main control outputs
module mips_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] pcout,
   input  logic [31:0] inst,
   output logic [4:0]  waddrout,
   output logic [31:0] wdout,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] aluop2out,
   output logic [31:0] aluout,
   input  logic [31:0] dmemout,
   output logic [2:0]  ALUCtr,
   output logic        RegDst,
   output logic        Jump,
   output logic        Branch,
   output logic        MemRead,
   output logic        MemtoReg,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic [1:0]  ALUOp
);

   logic [31:0] regs [32];
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_ext, pc4, pc_next;
   logic        zero;
   logic        unused_shamt;

   assign op    = inst[31:26];
   assign rs    = inst[25:21];
   assign rt    = inst[20:16];
   assign rd    = inst[15:11];
   assign funct = inst[5:0];
   assign unused_shamt = ^inst[10:6];

   assign imm_ext = {{16{inst[15]}}, inst[15:0]};

   // main control
   always_comb begin
      {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump} = 8'b0;
      ALUOp = 2'b00;
      case (op)
         6'b000000: begin RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 2'b10; end
         6'b100011: begin ALUSrc = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; end
         6'b101011: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
         6'b000100: begin Branch = 1'b1; ALUOp = 2'b01; end
         6'b000010: Jump = 1'b1;
         default: ;
      endcase
   end

   // ALU control
   always_comb begin
      ALUCtr = 3'b010;
      case (ALUOp)
         2'b01: ALUCtr = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: ALUCtr = 3'b110;
               6'b100100: ALUCtr = 3'b000;
               6'b100101: ALUCtr = 3'b001;
               6'b101010: ALUCtr = 3'b111;
               default:   ALUCtr = 3'b010;
            endcase
         end
         default: ALUCtr = 3'b010;
      endcase
   end

   // $0 is never written, but the read mux keeps it zero regardless of array contents
   assign rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];

   assign aluop2out = ALUSrc ? imm_ext : rd2;

   always_comb begin
      case (ALUCtr)
         3'b010:  aluout = rd1 + aluop2out;
         3'b110:  aluout = rd1 - aluop2out;
         3'b000:  aluout = rd1 & aluop2out;
         3'b001:  aluout = rd1 | aluop2out;
         3'b111:  aluout = {31'd0, $signed(rd1) < $signed(aluop2out)};
         default: aluout = 32'd0;
      endcase
   end

   assign zero     = (aluout == 32'd0);
   assign waddrout = RegDst ? rd : rt;
   assign wdout    = MemtoReg ? dmemout : aluout;

   assign pc4 = pcout + 32'd4;

   always_comb begin
      if (Jump)
         pc_next = {pc4[31:28], inst[25:0], 2'b00};
      else if (Branch && zero)
         pc_next = pc4 + {imm_ext[29:0], 2'b00};
      else
         pc_next = pc4;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pcout <= RESET_PC;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         pcout <= pc_next;
         if (RegWrite && waddrout != 5'd0) regs[waddrout] <= wdout;
      end
   end

endmodule

// File: tb/tb_mips_core.sv
module tb_mips_core;

   logic        clock, reset;
   logic [31:0] pcout, inst, wdout, rd1, rd2, aluop2out, aluout, dmemout;
   logic [4:0]  waddrout;
   logic [2:0]  ALUCtr;
   logic        RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
   logic [1:0]  ALUOp;

   mips_core dut (
      .clock(clock), .reset(reset), .pcout(pcout), .inst(inst),
      .waddrout(waddrout), .wdout(wdout), .rd1(rd1), .rd2(rd2),
      .aluop2out(aluop2out), .aluout(aluout), .dmemout(dmemout), .ALUCtr(ALUCtr),
      .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
      .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
      .RegWrite(RegWrite), .ALUOp(ALUOp)
   );

   localparam logic [31:0] NOP = 32'hFC00_0000;   // unsupported opcode: no-op
   localparam logic [9:0] C_R   = 10'b1001000010;
   localparam logic [9:0] C_LW  = 10'b0111100000;
   localparam logic [9:0] C_SW  = 10'b0100010000;
   localparam logic [9:0] C_BEQ = 10'b0000001001;
   localparam logic [9:0] C_J   = 10'b0000000100;

   // memories
   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic        use_ovr;
   logic [31:0] ovr_inst;

   assign inst    = use_ovr ? ovr_inst : imem[pcout[7:2]];
   assign dmemout = dmem[aluout[7:2]];

   always @(posedge clock) if (MemWrite) dmem[aluout[7:2]] <= rd2;

   // clock can be paused (held low) while registers are probed through the read port
   logic clk_en;
   initial begin
      clock = 1'b0;
      forever begin
         #5;
         if (clk_en) clock = ~clock;
      end
   end

   // scoreboard
   typedef enum {S_PC, S_ALU, S_WD, S_RD2, S_CTR, S_RW, S_MW, S_CTRL, S_REG, S_WA} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [4:0]  r;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input sel_e sel, input logic [4:0] r, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.r = r; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      clk_en = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            S_PC:   obs = pcout;
            S_ALU:  obs = aluout;
            S_WD:   obs = wdout;
            S_RD2:  obs = rd2;
            S_CTR:  obs = {29'd0, ALUCtr};
            S_RW:   obs = {31'd0, RegWrite};
            S_MW:   obs = {31'd0, MemWrite};
            S_WA:   obs = {27'd0, waddrout};
            S_CTRL: obs = {22'd0, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
                           MemWrite, Branch, Jump, ALUOp};
            default: begin
               ovr_inst = {6'h3f, e.r, 21'd0};
               use_ovr  = 1'b1;
               #1 obs   = rd1;
               use_ovr  = 1'b0;
               #1;
            end
         endcase
         chk(e.tag, obs, e.exp);
      end
      clk_en = 1'b1;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clock);
      push("pc_in_reset", S_PC, 0, 32'h0);
      drain();
      reset = 1'b1;
   endtask

   function automatic logic [31:0] lw(input logic [4:0] rs, rt, input logic [15:0] imm);
      return {6'h23, rs, rt, imm};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] rs, rt, input logic [15:0] imm);
      return {6'h2b, rs, rt, imm};
   endfunction
   function automatic logic [31:0] beq(input logic [4:0] rs, rt, input logic [15:0] imm);
      return {6'h04, rs, rt, imm};
   endfunction
   function automatic logic [31:0] jmp(input logic [25:0] a);
      return {6'h02, a};
   endfunction
   function automatic logic [31:0] rt_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) begin
         imem[i] = NOP;
         dmem[i] = 32'd0;
      end
   endtask

   logic [31:0] ealu [12];
   bit done;

   initial begin
      clk_en = 1'b1; use_ovr = 1'b0; ovr_inst = NOP; reset = 1'b0;

      // ---- multiply program (also covers reset and first lw) ----
      clear_mem();
      dmem[0] = 32'd33; dmem[1] = 32'd10; dmem[2] = 32'd1;
      imem[0] = lw(0, 1, 16'd0);
      imem[1] = lw(0, 2, 16'd4);
      imem[2] = lw(0, 3, 16'd8);
      imem[3] = beq(2, 5, 16'd3);
      imem[4] = rt_op(4, 1, 4, 6'b100000);
      imem[5] = rt_op(5, 3, 5, 6'b100000);
      imem[6] = jmp(26'd3);
      imem[7] = sw(0, 4, 16'h000c);
      do_reset();
      push("reset_pc", S_PC, 0, 32'h0);
      for (int r = 0; r < 32; r++) push($sformatf("reset_r%0d", r), S_REG, r[4:0], 32'd0);
      push("lw_ctrl", S_CTRL, 0, {22'd0, C_LW});
      push("lw_regwrite", S_RW, 0, 32'd1);
      push("lw_aluctr", S_CTR, 0, 32'd2);
      push("lw_aluout", S_ALU, 0, 32'd0);
      push("lw_wdout", S_WD, 0, 32'd33);
      drain();
      step();
      push("lw_pc", S_PC, 0, 32'd4);
      push("lw_r1", S_REG, 1, 32'd33);
      drain();
      done = 1'b0;
      for (int cyc = 1; cyc < 61 && !done; cyc++) begin
         if (pcout == 32'h1c) begin
            push("sw_ctrl", S_CTRL, 0, {22'd0, C_SW});
            push("sw_memwrite", S_MW, 0, 32'd1);
            push("sw_regwrite", S_RW, 0, 32'd0);
            push("sw_aluout", S_ALU, 0, 32'hc);
            push("sw_rd2", S_RD2, 0, 32'd330);
            drain();
         end
         step();
         if (dmem[3] == 32'd330) done = 1'b1;
      end
      chk("mul_done_in_budget", {31'd0, done}, 32'd1);
      chk("mul_dmem_c", dmem[3], 32'd330);
      push("mul_r4", S_REG, 4, 32'd330);
      push("mul_r5", S_REG, 5, 32'd10);
      drain();

      // ---- R-type ALU coverage ----
      clear_mem();
      dmem[1] = 32'd7; dmem[2] = 32'd5; dmem[3] = 32'hffff_ffff;
      imem[0]  = lw(0, 1, 16'd4);
      imem[1]  = lw(0, 2, 16'd8);
      imem[2]  = lw(0, 10, 16'd12);
      imem[3]  = rt_op(1, 2, 3, 6'b100000);
      imem[4]  = rt_op(1, 2, 4, 6'b100010);
      imem[5]  = rt_op(1, 2, 5, 6'b100100);
      imem[6]  = rt_op(1, 2, 6, 6'b100101);
      imem[7]  = rt_op(1, 2, 7, 6'b101010);
      imem[8]  = rt_op(2, 1, 8, 6'b101010);
      imem[9]  = rt_op(10, 8, 11, 6'b101010);
      imem[10] = rt_op(1, 2, 0, 6'b100000);
      imem[11] = sw(0, 3, 16'd16);
      ealu = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd2, 32'd5, 32'd7, 32'd0, 32'd1, 32'd1, 32'd12, 32'd16};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         push($sformatf("r_alu%0d", i), S_ALU, 0, ealu[i]);
         if (i >= 3 && i <= 10) push($sformatf("r_ctrl%0d", i), S_CTRL, 0, {22'd0, C_R});
         drain();
         step();
      end
      push("add_r3", S_REG, 3, 32'd12);
      push("sub_r4", S_REG, 4, 32'd2);
      push("and_r5", S_REG, 5, 32'd5);
      push("or_r6", S_REG, 6, 32'd7);
      push("slt_r7", S_REG, 7, 32'd0);
      push("slt_r8", S_REG, 8, 32'd1);
      push("slt_neg_r11", S_REG, 11, 32'd1);
      push("r0_ignored", S_REG, 0, 32'd0);
      drain();
      chk("sw_dmem10", dmem[4], 32'd12);

      // ---- branch not taken, jump, mid-program reset ----
      clear_mem();
      dmem[0] = 32'd33;
      imem[0] = lw(0, 1, 16'd0);
      imem[3] = beq(1, 0, 16'd3);
      imem[6] = jmp(26'd3);
      do_reset();
      step(); step(); step();
      push("beq_ctrl", S_CTRL, 0, {22'd0, C_BEQ});
      push("beq_pc", S_PC, 0, 32'hc);
      push("beq_alu", S_ALU, 0, 32'd33);
      drain();
      step();
      push("beq_nt_pc", S_PC, 0, 32'h10);
      drain();
      step(); step();
      push("j_ctrl", S_CTRL, 0, {22'd0, C_J});
      drain();
      step();
      push("j_pc", S_PC, 0, 32'hc);
      drain();
      reset = 1'b0;
      #1;
      push("midrst_pc", S_PC, 0, 32'h0);
      push("midrst_r1", S_REG, 1, 32'd0);
      drain();
      @(negedge clock);
      reset = 1'b1;

      // ---- branch taken ----
      imem[3] = beq(0, 0, 16'd3);
      step(); step(); step();
      push("beqt_ctrl", S_CTRL, 0, {22'd0, C_BEQ});
      push("beqt_alu", S_ALU, 0, 32'd0);
      drain();
      step();
      push("beq_t_pc", S_PC, 0, 32'h1c);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
